// File: rtl/mmio_bus_mux_pkg.sv
// Shared definitions for the MMIO bus multiplexer: FSM states, error cause
// codes, the error read-data constant and the project address prefixes.
// Optional feature macro: MMIO_BUS_MUX_APP_PROTECT_EN (application-mode protection).
package mmio_bus_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Error cause codes reported on err_cause
    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_PROTECT  = 2'd3;

    // Read data returned with any error response
    localparam logic [31:0] RDATA_ERR = 32'h0;

    // Project address map prefixes (top 8 address bits)
    localparam logic [7:0] PFX_ROM       = 8'h00;
    localparam logic [7:0] PFX_RAM       = 8'h01;
    localparam logic [3:0] PFX_MMIO_HI   = 4'hc;   // MMIO cores live at 8'hc0..8'hcf
    localparam logic [7:0] PFX_MMIO_UART = 8'hc0;
    localparam logic [7:0] PFX_MMIO_GPIO = 8'hc1;
    localparam logic [7:0] PFX_MMIO_TMR  = 8'hc2;

endpackage

// File: rtl/mmio_bus_mux_if.sv
// CPU-side memory bus (picorv32 native interface) seen by the multiplexer.
// Handshake: the CPU raises cpu_valid with addr/wstrb/wdata stable and keeps
// them until cpu_ready pulses high for one cycle; cpu_rdata is valid in that
// same cycle. cpu_wstrb == 0 means read.
interface mmio_bus_mux_if;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;

    modport master (
        output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
        input  cpu_ready, cpu_rdata
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
        output cpu_ready, cpu_rdata
    );
endinterface

// File: rtl/mmio_bus_mux_addr_decode.sv
// Combinational priority decoder: compares an address prefix against the
// per-slave prefix table; the lowest matching index wins. With
// MMIO_BUS_MUX_APP_PROTECT_EN defined it also flags firmware-only slaves
// addressed while the CPU runs in application mode.
module mmio_addr_decode
    import mmio_bus_mux_pkg::*;
#(
    parameter int                             NUM_SLAVES   = 8,
    parameter int                             PREFIX_W     = 8,
    parameter int                             IDX_W        = 3,
    parameter logic [NUM_SLAVES*PREFIX_W-1:0] SLV_PREFIXES = '0,
    parameter logic [NUM_SLAVES-1:0]          FW_ONLY_MASK = '0
) (
    input  logic [PREFIX_W-1:0] prefix,
    input  logic                fw_app_mode,
    output logic                hit,
    output logic [IDX_W-1:0]    index,
    output logic                prot
);

    // Scan from the top down so the lowest matching index is the last write
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (prefix == SLV_PREFIXES[i*PREFIX_W +: PREFIX_W]) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

`ifdef MMIO_BUS_MUX_APP_PROTECT_EN
    assign prot = hit & fw_app_mode & FW_ONLY_MASK[index];
`else
    // Protection disabled: mode input intentionally has no effect
    logic unused_mode;
    assign unused_mode = fw_app_mode;
    assign prot        = 1'b0;
`endif

endmodule

// File: rtl/mmio_bus_mux.sv
// Memory-mapped interconnect between the picorv32 native bus and NUM_SLAVES
// cores: prefix decode, one-hot chip select, bounded wait for the selected
// slave's ready, registered response and error reporting.
// Optional feature macro: MMIO_BUS_MUX_APP_PROTECT_EN.
module mmio_bus_mux
    import mmio_bus_mux_pkg::*;
#(
    parameter int                             NUM_SLAVES     = 8,
    parameter int                             PREFIX_W       = 8,
    parameter logic [NUM_SLAVES*PREFIX_W-1:0] SLV_PREFIXES   = '0,
    parameter int                             TIMEOUT_CYCLES = 16,
    parameter logic [NUM_SLAVES-1:0]          FW_ONLY_MASK   = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    mmio_bus_mux_if.slave              cpu,
    input  logic                       fw_app_mode,
    output logic [NUM_SLAVES-1:0]      slv_cs,
    output logic [3:0]                 slv_we,
    output logic [31:0]                slv_address,
    output logic [31:0]                slv_write_data,
    input  logic [NUM_SLAVES*32-1:0]   slv_read_data,
    input  logic [NUM_SLAVES-1:0]      slv_ready,
    output logic                       err_valid,
    output logic [1:0]                 err_cause,
    output logic [31:0]                err_addr,
    output state_t                     state_dbg
);

    localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t                  state_q, state_n;
    logic [IDX_W-1:0]        sel_q, sel_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic [31:0]             addr_q, addr_n;
    logic [3:0]              we_q, we_n;
    logic [31:0]             wdata_q, wdata_n;
    logic [NUM_SLAVES-1:0]   cs_q, cs_n;
    logic                    ready_q, ready_n;
    logic [31:0]             rdata_q, rdata_n;
    logic                    errv_q, errv_n;
    logic [1:0]              cause_q, cause_n;
    logic [31:0]             eaddr_q, eaddr_n;

    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_prot;

    mmio_addr_decode #(
        .NUM_SLAVES   (NUM_SLAVES),
        .PREFIX_W     (PREFIX_W),
        .IDX_W        (IDX_W),
        .SLV_PREFIXES (SLV_PREFIXES),
        .FW_ONLY_MASK (FW_ONLY_MASK)
    ) u_decode (
        .prefix      (cpu.cpu_addr[31 -: PREFIX_W]),
        .fw_app_mode (fw_app_mode),
        .hit         (dec_hit),
        .index       (dec_idx),
        .prot        (dec_prot)
    );

    // Register all state; synchronous reset abandons any transaction silently
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            cs_q    <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            errv_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            eaddr_q <= '0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            cnt_q   <= cnt_n;
            addr_q  <= addr_n;
            we_q    <= we_n;
            wdata_q <= wdata_n;
            cs_q    <= cs_n;
            ready_q <= ready_n;
            rdata_q <= rdata_n;
            errv_q  <= errv_n;
            cause_q <= cause_n;
            eaddr_q <= eaddr_n;
        end
    end

    // Next-state and next-output logic; response strobes default low
    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        cnt_n   = cnt_q;
        addr_n  = addr_q;
        we_n    = we_q;
        wdata_n = wdata_q;
        cs_n    = cs_q;
        ready_n = 1'b0;
        rdata_n = rdata_q;
        errv_n  = 1'b0;
        cause_n = cause_q;
        eaddr_n = eaddr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                cs_n  = '0;
                if (cpu.cpu_valid) begin
                    addr_n  = cpu.cpu_addr;
                    we_n    = cpu.cpu_wstrb;
                    wdata_n = cpu.cpu_wdata;
                    if (dec_hit && !dec_prot) begin
                        sel_n          = dec_idx;
                        cs_n[dec_idx]  = 1'b1;
                        state_n        = ST_ACCESS;
                    end else begin
                        // Refused requests answer at once and never touch a slave
                        rdata_n = RDATA_ERR;
                        ready_n = 1'b1;
                        errv_n  = 1'b1;
                        cause_n = dec_prot ? CAUSE_PROTECT : CAUSE_UNMAPPED;
                        eaddr_n = cpu.cpu_addr;
                        state_n = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready is checked first so a ready on the last allowed cycle wins
                if (slv_ready[sel_q]) begin
                    rdata_n = slv_read_data[{sel_q, 5'd0} +: 32];
                    cs_n    = '0;
                    ready_n = 1'b1;
                    state_n = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TO_LAST)) begin
                    rdata_n = RDATA_ERR;
                    cs_n    = '0;
                    ready_n = 1'b1;
                    errv_n  = 1'b1;
                    cause_n = CAUSE_TIMEOUT;
                    eaddr_n = addr_q;
                    state_n = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
            default: begin
                cs_n    = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign cpu.cpu_ready  = ready_q;
    assign cpu.cpu_rdata  = rdata_q;
    assign slv_cs         = cs_q;
    assign slv_we         = we_q;
    assign slv_address    = addr_q;
    assign slv_write_data = wdata_q;
    assign err_valid      = errv_q;
    assign err_cause      = cause_q;
    assign err_addr       = eaddr_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_mmio_bus_mux.sv
// Self-checking bench for mmio_bus_mux: behavioural slaves with per-slave
// ready latency, a transaction-level reference model and directed plus
// randomized scenarios.
module tb_mmio_bus_mux;
    import mmio_bus_mux_pkg::*;

    localparam int NS      = 8;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;
    localparam logic [NS*8-1:0] PFX_TABLE =
        {8'hc5, 8'hc1, 8'hc4, 8'hc3, 8'hc2, 8'hc1, 8'h01, 8'h00};
    localparam logic [NS-1:0] FW_MASK = 8'b0000_0100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mmio_bus_mux_if cpu ();
    logic              fw_app_mode = 1'b0;
    logic [NS-1:0]     slv_cs;
    logic [3:0]        slv_we;
    logic [31:0]       slv_address;
    logic [31:0]       slv_write_data;
    logic [NS*32-1:0]  slv_read_data;
    logic [NS-1:0]     slv_ready;
    logic              err_valid;
    logic [1:0]        err_cause;
    logic [31:0]       err_addr;
    state_t            state_dbg;

    mmio_bus_mux #(
        .NUM_SLAVES     (NS),
        .PREFIX_W       (8),
        .SLV_PREFIXES   (PFX_TABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FW_ONLY_MASK   (FW_MASK)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu            (cpu.slave),
        .fw_app_mode    (fw_app_mode),
        .slv_cs         (slv_cs),
        .slv_we         (slv_we),
        .slv_address    (slv_address),
        .slv_write_data (slv_write_data),
        .slv_read_data  (slv_read_data),
        .slv_ready      (slv_ready),
        .err_valid      (err_valid),
        .err_cause      (err_cause),
        .err_addr       (err_addr),
        .state_dbg      (state_dbg)
    );

    // ---------------- behavioural slaves ----------------
    logic [7:0]  pfx [NS] = '{8'h00, 8'h01, 8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc1, 8'hc5};
    int          slv_lat [NS];
    logic [31:0] rd_val [NS];
    int          cs_cnt [NS];
    logic [NS-1:0] ready_noise = '0;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) cs_cnt[i] <= slv_cs[i] ? cs_cnt[i] + 1 : 0;
    end

    always_comb begin
        slv_ready     = '0;
        slv_read_data = '0;
        for (int i = 0; i < NS; i++) begin
            slv_ready[i] = (slv_cs[i] && cs_cnt[i] >= slv_lat[i]) || ready_noise[i];
            slv_read_data[i*32 +: 32] = rd_val[i];
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    // Transaction-level expectation from the address map and slave behaviour
    function automatic void ref_model(input logic [31:0] addr, input logic mode,
                                      output int tgt, output int exp_lat,
                                      output logic [31:0] exp_rd, output logic [1:0] exp_cause,
                                      output int exp_cs);
        logic prot;
        tgt = -1;
        for (int i = 0; i < NS; i++) if (tgt < 0 && addr[31:24] == pfx[i]) tgt = i;
        prot = 1'b0;
`ifdef MMIO_BUS_MUX_APP_PROTECT_EN
        if (tgt >= 0) prot = FW_MASK[tgt] && mode;
`endif
        if (tgt < 0) begin
            exp_lat = 1; exp_rd = 32'h0; exp_cause = 2'd1; exp_cs = 0;
        end else if (prot) begin
            exp_lat = 1; exp_rd = 32'h0; exp_cause = 2'd3; exp_cs = 0;
        end else if (slv_lat[tgt] >= TIMEOUT) begin
            exp_lat = TIMEOUT + 1; exp_rd = 32'h0; exp_cause = 2'd2; exp_cs = TIMEOUT;
        end else begin
            exp_lat = slv_lat[tgt] + 2; exp_rd = rd_val[tgt]; exp_cause = 2'd0;
            exp_cs = slv_lat[tgt] + 1;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic errv,
                          output logic [1:0] cause, output logic [31:0] eaddr,
                          output int cs_cycles, output logic [NS-1:0] cs_seen,
                          output logic stable, output logic extra);
        @(negedge clk);
        cpu.cpu_valid = 1'b1;
        cpu.cpu_addr  = addr;
        cpu.cpu_wstrb = wstrb;
        cpu.cpu_wdata = wdata;
        lat = -1; rdata = 32'hdead_beef; errv = 1'b0; cause = 2'd0; eaddr = 32'h0;
        cs_cycles = 0; cs_seen = '0; stable = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (slv_cs != '0) begin
                cs_cycles++;
                cs_seen |= slv_cs;
                if ($countones(slv_cs) != 1 || slv_address !== addr ||
                    slv_write_data !== wdata || slv_we !== wstrb) stable = 1'b0;
            end
            if (cpu.cpu_ready) begin
                lat = c; rdata = cpu.cpu_rdata; errv = err_valid;
                cause = err_cause; eaddr = err_addr;
                break;
            end
        end
        cpu.cpu_valid = 1'b0;
        @(negedge clk);
        extra = cpu.cpu_ready | err_valid | (slv_cs != '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cpu.cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", cpu.cpu_ready); end
        checks++; if (cpu.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", cpu.cpu_rdata); end
        checks++; if (slv_cs !== '0 || slv_we !== 4'h0) begin errors++; $display("FAIL reset_cs_we: got %0h/%0h expected 0/0", slv_cs, slv_we); end
        checks++; if (slv_address !== 32'h0 || slv_write_data !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata: got %0h/%0h expected 0/0", slv_address, slv_write_data); end
        checks++; if (err_valid !== 1'b0 || err_cause !== 2'd0 || err_addr !== 32'h0) begin errors++; $display("FAIL reset_err: got %0b/%0d/%0h expected 0/0/0", err_valid, err_cause, err_addr); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_comb_read();
        int lat, csc; logic [31:0] rd, ea; logic ev, st, ex; logic [1:0] ca; logic [NS-1:0] cs;
        slv_lat[2] = 0; rd_val[2] = 32'hcafe_f00d;
        do_txn(32'hc100_0004, 4'h0, 32'h0, lat, rd, ev, ca, ea, csc, cs, st, ex);
        checks++; if (lat != 2) begin errors++; $display("FAIL comb_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hcafe_f00d) begin errors++; $display("FAIL comb_rdata: got %0h expected cafef00d", rd); end
        checks++; if (cs !== 8'b0000_0100 || csc != 1) begin errors++; $display("FAIL comb_cs: got %0b x%0d expected 100 x1", cs, csc); end
        checks++; if (!st || ev !== 1'b0 || ex) begin errors++; $display("FAIL comb_bus: got stable=%0b errv=%0b extra=%0b expected 1/0/0", st, ev, ex); end
    endtask

    task automatic test_delayed_write();
        int lat, csc; logic [31:0] rd, ea; logic ev, st, ex; logic [1:0] ca; logic [NS-1:0] cs;
        slv_lat[3] = 5;
        do_txn(32'hc200_0010, 4'hf, 32'h1234_5678, lat, rd, ev, ca, ea, csc, cs, st, ex);
        checks++; if (csc != 6 || cs !== 8'b0000_1000) begin errors++; $display("FAIL delay_cs: got %0b x%0d expected 1000 x6", cs, csc); end
        checks++; if (!st) begin errors++; $display("FAIL delay_stable: got 0 expected 1"); end
        checks++; if (lat != 7 || ev !== 1'b0 || ex) begin errors++; $display("FAIL delay_resp: got lat=%0d errv=%0b extra=%0b expected 7/0/0", lat, ev, ex); end
    endtask

    task automatic test_timeout();
        int lat, csc; logic [31:0] rd, ea; logic ev, st, ex; logic [1:0] ca; logic [NS-1:0] cs;
        slv_lat[4] = NEVER;
        ready_noise = 8'b1110_1111;   // other slaves shout ready; must be ignored
        do_txn(32'hc300_0abc, 4'h0, 32'h0, lat, rd, ev, ca, ea, csc, cs, st, ex);
        ready_noise = '0;
        checks++; if (csc != TIMEOUT || cs !== 8'b0001_0000) begin errors++; $display("FAIL timeout_cs: got %0b x%0d expected 10000 x%0d", cs, csc, TIMEOUT); end
        checks++; if (lat != TIMEOUT + 1 || rd !== 32'h0) begin errors++; $display("FAIL timeout_resp: got lat=%0d rd=%0h expected %0d/0", lat, rd, TIMEOUT + 1); end
        checks++; if (ev !== 1'b1 || ca !== 2'd2 || ea !== 32'hc300_0abc) begin errors++; $display("FAIL timeout_err: got %0b/%0d/%0h expected 1/2/c3000abc", ev, ca, ea); end
    endtask

    task automatic test_ready_at_limit();
        int lat, csc; logic [31:0] rd, ea; logic ev, st, ex; logic [1:0] ca; logic [NS-1:0] cs;
        slv_lat[5] = TIMEOUT - 1; rd_val[5] = 32'h5a5a_0f0f;
        do_txn(32'hc400_0000, 4'h0, 32'h0, lat, rd, ev, ca, ea, csc, cs, st, ex);
        checks++; if (lat != TIMEOUT + 1 || rd !== 32'h5a5a_0f0f) begin errors++; $display("FAIL limit_resp: got lat=%0d rd=%0h expected %0d/5a5a0f0f", lat, rd, TIMEOUT + 1); end
        checks++; if (ev !== 1'b0 || ca !== 2'd2) begin errors++; $display("FAIL limit_err_hold: got errv=%0b cause=%0d expected 0/2", ev, ca); end
    endtask

    task automatic test_unmapped();
        int lat, csc; logic [31:0] rd, ea; logic ev, st, ex; logic [1:0] ca; logic [NS-1:0] cs;
        ready_noise = '1;   // ready in IDLE must not matter
        do_txn(32'h9000_0000, 4'h0, 32'h0, lat, rd, ev, ca, ea, csc, cs, st, ex);
        ready_noise = '0;
        checks++; if (lat != 1 || rd !== 32'h0) begin errors++; $display("FAIL unmapped_resp: got lat=%0d rd=%0h expected 1/0", lat, rd); end
        checks++; if (ev !== 1'b1 || ca !== 2'd1 || ea !== 32'h9000_0000) begin errors++; $display("FAIL unmapped_err: got %0b/%0d/%0h expected 1/1/90000000", ev, ca, ea); end
        do_txn(32'h9100_0008, 4'h3, 32'hffff_0000, lat, rd, ev, ca, ea, csc, cs, st, ex);
        checks++; if (cs !== '0 || lat != 1 || ex) begin errors++; $display("FAIL unmapped_write: got cs=%0b lat=%0d extra=%0b expected 0/1/0", cs, lat, ex); end
    endtask

    task automatic test_reset_mid();
        int lat, csc; logic [31:0] rd, ea; logic ev, st, ex; logic [1:0] ca; logic [NS-1:0] cs;
        slv_lat[4] = NEVER;
        @(negedge clk);
        cpu.cpu_valid = 1'b1; cpu.cpu_addr = 32'hc300_0040; cpu.cpu_wstrb = 4'h0; cpu.cpu_wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0; cpu.cpu_valid = 1'b0;
        @(negedge clk);
        checks++; if (slv_cs !== '0 || cpu.cpu_ready !== 1'b0 || state_dbg !== ST_IDLE) begin errors++; $display("FAIL midreset_state: got cs=%0b ready=%0b state=%0d expected 0/0/0", slv_cs, cpu.cpu_ready, state_dbg); end
        reset_n = 1'b1;
        slv_lat[2] = 0; rd_val[2] = 32'h0bad_cafe;
        do_txn(32'hc100_0000, 4'h0, 32'h0, lat, rd, ev, ca, ea, csc, cs, st, ex);
        checks++; if (lat != 2 || rd !== 32'h0bad_cafe || ev !== 1'b0) begin errors++; $display("FAIL midreset_next: got lat=%0d rd=%0h errv=%0b expected 2/0badcafe/0", lat, rd, ev); end
    endtask

    task automatic test_protect();
        int lat, csc; logic [31:0] rd, ea; logic ev, st, ex; logic [1:0] ca; logic [NS-1:0] cs;
        slv_lat[2] = 0; rd_val[2] = 32'h7777_1111;
        fw_app_mode = 1'b1;
        do_txn(32'hc100_0020, 4'h0, 32'h0, lat, rd, ev, ca, ea, csc, cs, st, ex);
`ifdef MMIO_BUS_MUX_APP_PROTECT_EN
        checks++; if (cs !== '0 || lat != 1 || rd !== 32'h0) begin errors++; $display("FAIL protect_refused: got cs=%0b lat=%0d rd=%0h expected 0/1/0", cs, lat, rd); end
        checks++; if (ev !== 1'b1 || ca !== 2'd3 || ea !== 32'hc100_0020) begin errors++; $display("FAIL protect_err: got %0b/%0d/%0h expected 1/3/c1000020", ev, ca, ea); end
`else
        checks++; if (cs !== 8'b0000_0100 || lat != 2 || rd !== 32'h7777_1111 || ev !== 1'b0) begin errors++; $display("FAIL protect_off: got cs=%0b lat=%0d rd=%0h errv=%0b expected 100/2/77771111/0", cs, lat, rd, ev); end
`endif
        fw_app_mode = 1'b0;
        do_txn(32'hc100_0020, 4'h0, 32'h0, lat, rd, ev, ca, ea, csc, cs, st, ex);
        checks++; if (lat != 2 || rd !== 32'h7777_1111 || ev !== 1'b0) begin errors++; $display("FAIL protect_fwmode: got lat=%0d rd=%0h errv=%0b expected 2/77771111/0", lat, rd, ev); end
    endtask

    // Valid held high: each response must be followed by a fresh transaction
    task automatic test_back_to_back();
        logic [31:0] addrs [2] = '{32'hc100_0010, 32'h8800_0000};
        int single [2] = '{2, 1};
        slv_lat[2] = 0;
        for (int t = 0; t < 2; t++) begin
            logic [15:0] seen, exp_mask;
            seen = '0; exp_mask = '0;
            for (int c = single[t]; c <= 8; c += single[t] + 1) exp_mask[c] = 1'b1;
            @(negedge clk);
            cpu.cpu_valid = 1'b1; cpu.cpu_addr = addrs[t]; cpu.cpu_wstrb = 4'h0; cpu.cpu_wdata = 32'h0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (cpu.cpu_ready) seen[c] = 1'b1;
            end
            cpu.cpu_valid = 1'b0;
            repeat (4) @(negedge clk);
            checks++; if (seen !== exp_mask) begin errors++; $display("FAIL b2b_%0d: got %0h expected %0h", t, seen, exp_mask); end
        end
    endtask

    task automatic test_random();
        int lat, csc, tgt, e_lat, e_cs; logic [31:0] rd, ea, e_rd, addr, exp_rd;
        logic ev, st, ex, mode; logic [1:0] ca, e_ca; logic [NS-1:0] cs, e_sel;
        for (int n = 0; n < 40; n++) begin
            int r;
            for (int i = 0; i < NS; i++) begin
                int l;
                l = $urandom_range(0, 19);
                slv_lat[i] = (l >= TIMEOUT) ? NEVER : l;
                rd_val[i]  = $urandom;
            end
            r = $urandom_range(0, 9);
            addr = $urandom;
            addr[31:24] = (r < NS) ? pfx[r] : (8'h80 | 8'($urandom_range(0, 15)));
            mode = 1'($urandom_range(0, 1));
            fw_app_mode = mode;
            ref_model(addr, mode, tgt, e_lat, e_rd, e_ca, e_cs);
            exp_q.push_back(e_rd);
            e_sel = (e_cs > 0) ? (NS'(1) << tgt) : '0;
            do_txn(addr, 4'($urandom_range(0, 15)), $urandom, lat, rd, ev, ca, ea, csc, cs, st, ex);
            exp_rd = exp_q.pop_front();
            checks++; if (lat != e_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, e_lat); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d]: got %0h expected %0h", n, rd, exp_rd); end
            checks++; if (cs !== e_sel || csc != e_cs || !st) begin errors++; $display("FAIL rand_cs[%0d]: got %0b x%0d stable=%0b expected %0b x%0d", n, cs, csc, st, e_sel, e_cs); end
            checks++; if (ev !== (e_ca != 2'd0) || ex) begin errors++; $display("FAIL rand_errv[%0d]: got %0b extra=%0b expected %0b", n, ev, ex, e_ca != 2'd0); end
            if (e_ca != 2'd0) begin
                checks++; if (ca !== e_ca || ea !== addr) begin errors++; $display("FAIL rand_cause[%0d]: got %0d/%0h expected %0d/%0h", n, ca, ea, e_ca, addr); end
            end
        end
        fw_app_mode = 1'b0;
    endtask

    initial begin
        cpu.cpu_valid = 1'b0; cpu.cpu_addr = 32'h0; cpu.cpu_wstrb = 4'h0; cpu.cpu_wdata = 32'h0;
        for (int i = 0; i < NS; i++) begin slv_lat[i] = 0; rd_val[i] = 32'h0; cs_cnt[i] = 0; end
        test_reset();
        test_comb_read();
        test_delayed_write();
        test_timeout();
        test_ready_at_limit();
        test_unmapped();
        test_reset_mid();
        test_protect();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
